// File: rtl/bft_leaf_port_pkg.sv
// Shared definitions for the BFT leaf port: packet field helpers,
// output-slot selection encoding and bounce counter limits.
package bft_leaf_port_pkg;

  // Bounce counter width and saturation value.
  localparam int unsigned bounce_cnt_w   = 16;
  localparam logic [15:0] bounce_cnt_max = 16'hFFFF;

  // Which source owns the outbound bus slot in a given cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_BOUNCE = 2'd1,
    SLOT_TX     = 2'd2
  } slot_e;

  // Destination address width for a tree with the given number of leaves.
  function automatic int unsigned addr_width(input int unsigned leaves);
    return (leaves > 1) ? $clog2(leaves) : 1;
  endfunction

  // Packet layout is {valid, dest, payload}; these give the field positions.
  function automatic int unsigned pkt_valid_bit(input int unsigned leaves,
                                                input int unsigned payload);
    return addr_width(leaves) + payload;
  endfunction

  function automatic int unsigned pkt_dest_hi(input int unsigned leaves,
                                              input int unsigned payload);
    return addr_width(leaves) + payload - 1;
  endfunction

  function automatic int unsigned pkt_dest_lo(input int unsigned payload);
    return payload;
  endfunction

  function automatic int unsigned pkt_payload_hi(input int unsigned payload);
    return payload - 1;
  endfunction

endpackage

// File: rtl/bft_leaf_port_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
// Pointers carry one extra wrap bit so full and empty are told apart
// by comparing the MSBs. Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             empty
);

  localparam int aw = $clog2(depth);

  logic [aw:0]      wr_ptr_reg;
  logic [aw:0]      rd_ptr_reg;
  logic [aw:0]      wr_ptr_next;
  logic [aw:0]      rd_ptr_next;
  logic             do_push;
  logic             do_pop;
  logic [width-1:0] entry_q [depth];

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[aw] != rd_ptr_reg[aw]) &&
                    (wr_ptr_reg[aw-1:0] == rd_ptr_reg[aw-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head entry is visible combinationally so the consumer sees data the
  // cycle after it was written.
  assign pop_data = entry_q[rd_ptr_reg[aw-1:0]];

  // Storage: each entry loads only when the write pointer selects it.
  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_entry
      logic [width-1:0] entry_reg;
      // Capture push data into this slot.
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg[aw-1:0] == aw'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // Next-pointer arithmetic.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + {{aw{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_next = rd_ptr_reg + {{aw{1'b0}}, 1'b1};
  end

  // Pointer registers; reset empties the FIFO without clearing storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

endmodule

// File: rtl/bft_leaf_port.sv
// Leaf endpoint of the BFT tree. Queues PE sends into a TX FIFO and puts
// them on the switch bus one per cycle; accepts packets addressed to this
// leaf into an RX FIFO. Because the tree has no backpressure, misrouted
// packets and packets that find RX full are bounced straight back onto the
// bus, taking priority over local sends.
module bft_leaf_port
  import bft_leaf_port_pkg::*;
#(
  parameter int num_leaves = 2,
  parameter int payload_sz = 1,
  parameter int addr       = 0,
  parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int tx_depth   = 16,
  parameter int rx_depth   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_sz-1:0]               bus_i,
  output logic [p_sz-1:0]               bus_o,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(num_leaves)-1:0] in_dest,
  input  logic [payload_sz-1:0]         in_payload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [payload_sz-1:0]         out_payload,
  output logic [15:0]                   bounce_cnt
);

  localparam int aw         = $clog2(num_leaves);
  localparam int valid_bit  = pkt_valid_bit(num_leaves, payload_sz);
  localparam int dest_hi    = pkt_dest_hi(num_leaves, payload_sz);
  localparam int dest_lo    = pkt_dest_lo(payload_sz);
  localparam int payload_hi = pkt_payload_hi(payload_sz);
  localparam logic [aw-1:0] my_addr = aw'(addr);

  // Incoming packet fields.
  logic                  bus_valid;
  logic [aw-1:0]         bus_dest;
  logic [payload_sz-1:0] bus_payload;

  assign bus_valid   = bus_i[valid_bit];
  assign bus_dest    = bus_i[dest_hi:dest_lo];
  assign bus_payload = bus_i[payload_hi:0];

  // TX FIFO holds {dest, payload}; the valid bit is added on the way out.
  logic                 tx_push;
  logic                 tx_pop;
  logic                 tx_full;
  logic                 tx_empty;
  logic [p_sz-2:0]      tx_head;

  // RX FIFO holds payload only.
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_full;
  logic                 rx_empty;

  logic                 bounce;
  slot_e                slot_sel;
  logic [p_sz-1:0]      bus_o_reg;
  logic [p_sz-1:0]      bus_o_next;
  logic [15:0]          bounce_cnt_reg;

  assign in_ready  = !tx_full;
  assign tx_push   = in_valid && in_ready;
  assign out_valid = !rx_empty;
  assign rx_pop    = out_valid && out_ready;

  // Receive classifier: accept local packets while RX has room (fullness
  // taken before this cycle's pop), bounce everything else that is valid.
  // Traffic arriving during reset is dropped.
  always_comb begin
    rx_push = 1'b0;
    bounce  = 1'b0;
    if (!reset && bus_valid) begin
      if ((bus_dest == my_addr) && !rx_full) begin
        rx_push = 1'b1;
      end else begin
        bounce  = 1'b1;
      end
    end
  end

  // Output slot arbitration: bounce first, then the TX head, else idle.
  always_comb begin
    slot_sel   = SLOT_IDLE;
    tx_pop     = 1'b0;
    bus_o_next = '0;
    if (bounce) begin
      slot_sel   = SLOT_BOUNCE;
      bus_o_next = bus_i;
    end else if (!tx_empty) begin
      slot_sel   = SLOT_TX;
      tx_pop     = 1'b1;
      bus_o_next = {1'b1, tx_head};
    end
  end

  // Registered outbound bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_o_reg <= '0;
    end else begin
      bus_o_reg <= bus_o_next;
    end
  end

  // Saturating bounce counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      bounce_cnt_reg <= '0;
    end else if ((slot_sel == SLOT_BOUNCE) && (bounce_cnt_reg != bounce_cnt_max)) begin
      bounce_cnt_reg <= bounce_cnt_reg + 16'd1;
    end
  end

  assign bus_o      = bus_o_reg;
  assign bounce_cnt = bounce_cnt_reg;

  sync_fifo #(
    .width (p_sz - 1),
    .depth (tx_depth)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data ({in_dest, in_payload}),
    .full      (tx_full),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .empty     (tx_empty)
  );

  sync_fifo #(
    .width (payload_sz),
    .depth (rx_depth)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (bus_payload),
    .full      (rx_full),
    .pop       (rx_pop),
    .pop_data  (out_payload),
    .empty     (rx_empty)
  );

endmodule

// File: tb/tb_bft_leaf_port.sv
// Scoreboard bench for bft_leaf_port (8 leaves, 32-bit payload, addr 3,
// 4-entry FIFOs). A queue-based reference model predicts each bus_o packet
// with the cycle it must appear, every RX delivery, the bounce count and
// ready/valid flags; a negedge monitor compares the DUT against them.
module tb_bft_leaf_port;

  localparam int NL = 8;
  localparam int PS = 32;
  localparam int AD = 3;
  localparam int P  = 36;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [P-1:0]  bus_i;
  logic [P-1:0]  bus_o;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_dest;
  logic [PS-1:0] in_payload;
  logic          out_valid;
  logic          out_ready;
  logic [PS-1:0] out_payload;
  logic [15:0]   bounce_cnt;

  bft_leaf_port #(
    .num_leaves (NL),
    .payload_sz (PS),
    .addr       (AD),
    .tx_depth   (TXD),
    .rx_depth   (RXD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_i       (bus_i),
    .bus_o       (bus_o),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .bounce_cnt  (bounce_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [P-1:0] pkt;
  } exp_t;

  // Reference model state.
  logic [P-2:0]  txq[$];
  exp_t          exp_bus[$];
  logic [PS-1:0] exp_rx[$];
  int            rx_cnt  = 0;
  int            bcnt    = 0;
  int            cyc     = 0;
  bit            started = 0;

  int checks = 0;
  int errors = 0;

  // Reference model: advances once per rising edge from the applied inputs.
  always @(posedge clk) begin
    int  rx_before;
    int  tx_before;
    bit  bnc;
    cyc++;
    if (reset) begin
      txq.delete();
      exp_bus.delete();
      exp_rx.delete();
      rx_cnt  = 0;
      bcnt    = 0;
      started = 1;
    end else if (started) begin
      rx_before = rx_cnt;
      tx_before = txq.size();
      bnc       = 0;
      if (out_ready && rx_before > 0) rx_cnt--;
      if (bus_i[P-1]) begin
        if (bus_i[P-2:PS] == 3'(AD) && rx_before < RXD) begin
          exp_rx.push_back(bus_i[PS-1:0]);
          rx_cnt++;
        end else begin
          bnc = 1;
          if (bcnt < 65535) bcnt++;
          exp_bus.push_back('{cyc, bus_i});
        end
      end
      if (!bnc && tx_before > 0) exp_bus.push_back('{cyc, {1'b1, txq.pop_front()}});
      if (in_valid && tx_before < TXD) txq.push_back({in_dest, in_payload});
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the model's predictions.
  always @(negedge clk) begin
    exp_t          e;
    logic [PS-1:0] p;
    if (started) begin
      while (exp_bus.size() > 0 && exp_bus[0].cyc < cyc) begin
        e = exp_bus.pop_front();
        checks++; errors++;
        $display("FAIL bus_o_missed cyc=%0d actual=none required=%h", cyc, e.pkt);
      end
      checks++;
      if (exp_bus.size() > 0 && exp_bus[0].cyc == cyc) begin
        e = exp_bus.pop_front();
        if (bus_o !== e.pkt) begin
          errors++;
          $display("FAIL bus_o cyc=%0d actual=%h required=%h", cyc, bus_o, e.pkt);
        end else begin
          $display("bus_o cyc=%0d pkt=%h ok", cyc, bus_o);
        end
      end else if (bus_o !== '0) begin
        errors++;
        $display("FAIL bus_o_idle cyc=%0d actual=%h required=0", cyc, bus_o);
      end
      checks++;
      if (bounce_cnt !== 16'(bcnt)) begin
        errors++;
        $display("FAIL bounce_cnt cyc=%0d actual=%0d required=%0d", cyc, bounce_cnt, bcnt);
      end
      checks++;
      if (in_ready !== (txq.size() < TXD)) begin
        errors++;
        $display("FAIL in_ready cyc=%0d actual=%b required=%b", cyc, in_ready, txq.size() < TXD);
      end
      checks++;
      if (out_valid !== (rx_cnt > 0)) begin
        errors++;
        $display("FAIL out_valid cyc=%0d actual=%b required=%b", cyc, out_valid, rx_cnt > 0);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected cyc=%0d actual=%h required=none", cyc, out_payload);
        end else begin
          p = exp_rx.pop_front();
          if (out_payload !== p) begin
            errors++;
            $display("FAIL rx_payload cyc=%0d actual=%h required=%h", cyc, out_payload, p);
          end else begin
            $display("rx cyc=%0d payload=%h ok", cyc, out_payload);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [2:0] d, input logic [PS-1:0] pl,
                       input logic [P-1:0] b, input bit ordy);
    in_valid   = iv;
    in_dest    = d;
    in_payload = pl;
    bus_i      = b;
    out_ready  = ordy;
  endtask

  function automatic logic [P-1:0] pkt(input logic [2:0] d, input logic [PS-1:0] pl);
    return {1'b1, d, pl};
  endfunction

  initial begin
    reset = 1'b1;
    drive(0, 3'd0, '0, '0, 0);

    // 1: reset held two cycles with valid traffic on bus_i.
    tick();
    drive(0, 3'd0, '0, pkt(3'd3, 32'hDEAD0000), 1);
    tick();
    drive(0, 3'd0, '0, pkt(3'd6, 32'hDEAD0001), 1);
    tick();
    reset = 1'b0;
    drive(0, 3'd0, '0, '0, 0);
    tick();

    // 2: single send to leaf 5.
    drive(1, 3'd5, 32'hCAFE0001, '0, 0);
    tick();
    drive(0, 3'd0, '0, '0, 0);
    repeat (3) tick();

    // 3: local packet delivered to RX.
    drive(0, 3'd0, '0, pkt(3'd3, 32'h12345678), 1);
    tick();
    drive(0, 3'd0, '0, '0, 1);
    repeat (3) tick();

    // 4: misroute while TX holds one packet.
    drive(1, 3'd1, 32'hAAAA5555, '0, 1);
    tick();
    drive(0, 3'd0, '0, pkt(3'd6, 32'h0BAD0BAD), 1);
    tick();
    drive(0, 3'd0, '0, '0, 1);
    repeat (3) tick();

    // 5: RX overflow bounces the fifth packet, then drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(0, 3'd0, '0, pkt(3'd3, 32'h50000000 + i), 0);
      tick();
    end
    drive(0, 3'd0, '0, '0, 1);
    repeat (6) tick();

    // 6: sustained bounces let TX fill; hold in_valid while full.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        drive(1, 3'($urandom_range(0, 7)), $urandom, pkt(3'd6, 32'h60000000 + i), 1);
        tick();
      end
      drive(0, 3'd0, '0, '0, 1);
      repeat (6) tick();
    end

    // Randomised traffic with a mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] bd;
      bd = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 4) ? pkt(bd, $urandom) : {1'b0, 3'($urandom_range(0, 7)), 32'($urandom)},
            $urandom_range(0, 9) < 7);
      reset = (i == 2000 || i == 2001);
      tick();
    end
    reset = 1'b0;

    // Drain everything still buffered.
    drive(0, 3'd0, '0, '0, 1);
    repeat (20) tick();
    @(negedge clk);
    #1;
    checks++;
    if (exp_bus.size() != 0 || exp_rx.size() != 0) begin
      errors++;
      $display("FAIL leftover actual=%0d/%0d required=0/0", exp_bus.size(), exp_rx.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
